// File: rtl/fp_md_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_md_pkg
//  Brief    : Shared types for the FP multiplier/divider sign and class path.
//  Revision : 1.0
// ============================================================================
package fp_md_pkg;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    typedef struct packed {
        logic s;
        logic nan;
        logic inf;
        logic zero;
        logic inv;
        logic dbz;
    } sign_res_t;

    localparam int MAX_LATENCY = 8;
    localparam int RES_W       = $bits(sign_res_t);

endpackage
`default_nettype wire

// File: rtl/sign_class_lane.sv
`default_nettype none
// ============================================================================
//  Module   : sign_class_lane
//  Brief    : Single-lane result sign and IEEE-754 special-case classification.
//  Revision : 1.0
// ============================================================================
module sign_class_lane
    import fp_md_pkg::*;
(
    input  op_e       i_op,
    input  logic      i_s_a,
    input  logic      i_s_b,
    input  fp_class_t i_a_cls,
    input  fp_class_t i_b_cls,
    output sign_res_t o_res
);

    logic w_nan_in;
    logic w_inv;
    logic w_nan;

    always_comb begin
        w_nan_in = i_a_cls.nan | i_b_cls.nan;
        if (i_op == OP_DIV) begin
            w_inv = (i_a_cls.inf & i_b_cls.inf) | (i_a_cls.zero & i_b_cls.zero);
        end else begin
            w_inv = (i_a_cls.inf & i_b_cls.zero) | (i_a_cls.zero & i_b_cls.inf);
        end
        w_nan = w_nan_in | w_inv;

        o_res      = '0;
        o_res.nan  = w_nan;
        // A NaN operand propagates quietly; only genuine 0*inf style cases are invalid.
        o_res.inv  = w_inv & ~w_nan_in;
        o_res.s    = w_nan ? 1'b0 : (i_s_a ^ i_s_b);
        if (i_op == OP_DIV) begin
            o_res.inf  = ~w_nan & (i_a_cls.inf | i_b_cls.zero);
            o_res.zero = ~w_nan & (i_a_cls.zero | i_b_cls.inf);
            o_res.dbz  = i_b_cls.zero & ~i_a_cls.zero & ~i_a_cls.inf & ~i_a_cls.nan;
        end else begin
            o_res.inf  = ~w_nan & (i_a_cls.inf | i_b_cls.inf);
            o_res.zero = ~w_nan & (i_a_cls.zero | i_b_cls.zero);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sign_class_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : sign_class_pipe
//  Brief    : Multi-lane sign/class unit with programmable-latency pipeline.
//  Revision : 1.0
// ============================================================================
module sign_class_pipe
    import fp_md_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic             flush,
    input  logic             valid_in,
    input  logic             op_div,
    input  logic [LANES-1:0] s_a,
    input  logic [LANES-1:0] s_b,
    input  logic [LANES-1:0] a_zero,
    input  logic [LANES-1:0] a_inf,
    input  logic [LANES-1:0] a_nan,
    input  logic [LANES-1:0] b_zero,
    input  logic [LANES-1:0] b_inf,
    input  logic [LANES-1:0] b_nan,
    output logic             valid_out,
    output logic [LANES-1:0] s_r,
    output logic [LANES-1:0] r_nan,
    output logic [LANES-1:0] r_inf,
    output logic [LANES-1:0] r_zero,
    output logic [LANES-1:0] r_inv,
    output logic [LANES-1:0] r_dbz
);

    localparam int c_DW = LANES * RES_W;

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("sign_class_pipe: LATENCY must be in 1..%0d", MAX_LATENCY);
    end

    op_e                w_op;
    logic [c_DW-1:0]    w_data;
    logic [c_DW-1:0]    r_data [LATENCY];
    logic [LATENCY-1:0] r_valid;

    assign w_op = op_e'(op_div);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fp_class_t w_a_cls;
        fp_class_t w_b_cls;
        sign_res_t w_lane_res;
        sign_res_t w_out_res;

        assign w_a_cls = '{zero: a_zero[l], inf: a_inf[l], nan: a_nan[l]};
        assign w_b_cls = '{zero: b_zero[l], inf: b_inf[l], nan: b_nan[l]};

        sign_class_lane u_lane (
            .i_op    (w_op),
            .i_s_a   (s_a[l]),
            .i_s_b   (s_b[l]),
            .i_a_cls (w_a_cls),
            .i_b_cls (w_b_cls),
            .o_res   (w_lane_res)
        );

        assign w_data[l*RES_W +: RES_W] = w_lane_res;
        assign w_out_res                = r_data[LATENCY-1][l*RES_W +: RES_W];

        assign s_r[l]    = w_out_res.s;
        assign r_nan[l]  = w_out_res.nan;
        assign r_inf[l]  = w_out_res.inf;
        assign r_zero[l] = w_out_res.zero;
        assign r_inv[l]  = w_out_res.inv;
        assign r_dbz[l]  = w_out_res.dbz;

        a_excl_a: assert property (@(posedge clk) disable iff (arst)
            valid_in |-> $onehot0({a_zero[l], a_inf[l], a_nan[l]}));
        a_excl_b: assert property (@(posedge clk) disable iff (arst)
            valid_in |-> $onehot0({b_zero[l], b_inf[l], b_nan[l]}));
    end

    // Flush only drops valid bits; data stays put since it is ignored while invalid.
    always_ff @(posedge clk) begin
        if (arst) begin
            r_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else if (en) begin
            r_valid[0] <= valid_in;
            r_data[0]  <= w_data;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign valid_out = r_valid[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_sign_class_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sign_class_pipe
//  Brief    : Self-checking bench; four pipelines (LATENCY 1,2,4,8) share stimulus.
//  Revision : 1.0
// ============================================================================
module tb_sign_class_pipe;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       arst, en, flush, valid_in, op_div;
    logic [1:0] s_a, s_b;
    int         ca [2];
    int         cb [2];
    logic [1:0] a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    logic [NI-1:0] vo;
    logic [11:0]   ro [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference history: enable-edge index at which each surviving item entered.
    int          nenc = 0;
    int          hk [$];
    logic [11:0] hd [$];

    always #5 clk = ~clk;

    // class codes: 0 finite nonzero, 1 zero, 2 inf, 3 nan
    assign a_zero = {ca[1] == 1, ca[0] == 1};
    assign a_inf  = {ca[1] == 2, ca[0] == 2};
    assign a_nan  = {ca[1] == 3, ca[0] == 3};
    assign b_zero = {cb[1] == 1, cb[0] == 1};
    assign b_inf  = {cb[1] == 2, cb[0] == 2};
    assign b_nan  = {cb[1] == 3, cb[0] == 3};

    for (genvar d = 0; d < NI; d++) begin : g_dut
        logic       w_v;
        logic [1:0] w_s, w_n, w_i, w_z, w_iv, w_dz;

        sign_class_pipe #(.LANES(2), .LATENCY(1 << d)) u_dut (
            .clk(clk), .arst(arst), .en(en), .flush(flush), .valid_in(valid_in),
            .op_div(op_div), .s_a(s_a), .s_b(s_b),
            .a_zero(a_zero), .a_inf(a_inf), .a_nan(a_nan),
            .b_zero(b_zero), .b_inf(b_inf), .b_nan(b_nan),
            .valid_out(w_v), .s_r(w_s), .r_nan(w_n), .r_inf(w_i),
            .r_zero(w_z), .r_inv(w_iv), .r_dbz(w_dz)
        );

        assign vo[d] = w_v;
        assign ro[d] = {w_s, w_n, w_i, w_z, w_iv, w_dz};
    end

    // IEEE-754 rules for special operands, returns {s,nan,inf,zero,inv,dbz}.
    function automatic logic [5:0] ref_lane(logic div, logic sa, logic sb, int a, int b);
        logic nan = 0, inf = 0, zero = 0, inv = 0, dbz = 0;
        if (a == 3 || b == 3) nan = 1;
        else if (!div) begin
            if ((a == 2 && b == 1) || (a == 1 && b == 2)) begin nan = 1; inv = 1; end
            else if (a == 2 || b == 2) inf = 1;
            else if (a == 1 || b == 1) zero = 1;
        end else begin
            if ((a == 2 && b == 2) || (a == 1 && b == 1)) begin nan = 1; inv = 1; end
            else if (a == 2) inf = 1;
            else if (b == 1) begin inf = 1; dbz = 1; end
            else if (a == 1 || b == 2) zero = 1;
        end
        return {nan ? 1'b0 : (sa ^ sb), nan, inf, zero, inv, dbz};
    endfunction

    function automatic logic [11:0] ref_data();
        logic [5:0] r0, r1;
        r0 = ref_lane(op_div, s_a[0], s_b[0], ca[0], cb[0]);
        r1 = ref_lane(op_div, s_a[1], s_b[1], ca[1], cb[1]);
        return {r1[5], r0[5], r1[4], r0[4], r1[3], r0[3], r1[2], r0[2], r1[1], r0[1], r1[0], r0[0]};
    endfunction

    function automatic logic exp_valid(int lat);
        foreach (hk[i]) if (hk[i] == nenc - lat + 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [11:0] exp_data(int lat);
        foreach (hk[i]) if (hk[i] == nenc - lat + 1) return hd[i];
        return 12'h000;
    endfunction

    task automatic step();
        @(posedge clk);
        if (arst || flush) begin
            hk.delete();
            hd.delete();
        end else if (en) begin
            nenc++;
            if (valid_in) begin
                hk.push_back(nenc);
                hd.push_back(ref_data());
            end
            while (hk.size() > 0 && hk[0] < nenc - 8) begin
                void'(hk.pop_front());
                void'(hd.pop_front());
            end
        end
        #1;
    endtask

    task automatic set_lane(int l, logic sa, int a, logic sb, int b);
        s_a[l] = sa; ca[l] = a;
        s_b[l] = sb; cb[l] = b;
    endtask

    task automatic idle();
        en = 1'b1; flush = 1'b0; valid_in = 1'b0; arst = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1; en = 1'b0; flush = 1'b0; valid_in = 1'b0; op_div = 1'b0;
        s_a = '0; s_b = '0; ca = '{0, 0}; cb = '{0, 0};
        step(); step();
        for (int d = 0; d < NI; d++) begin
            n_checks++;
            if (vo[d] !== 1'b0 || ro[d] !== 12'h000) begin
                n_fail++;
                $display("FAIL reset lat=%0d valid=%b data=%h expected valid=0 data=000", 1 << d, vo[d], ro[d]);
            end
        end
        arst = 1'b0;
    endtask

    task automatic test_mul_basic();
        idle();
        op_div = 1'b0; valid_in = 1'b1;
        set_lane(0, 1'b1, 0, 1'b0, 0);
        set_lane(1, 1'b1, 0, 1'b1, 0);
        step();
        valid_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin
                n_checks++;
                if (vo[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mul_basic_early lat=2 valid=%b expected 0", vo[1]);
                end
            end
            step();
            if (c == 0) begin
                n_checks++;
                if (vo[1] !== 1'b1 || ro[1] !== 12'h400) begin
                    n_fail++;
                    $display("FAIL mul_basic lat=2 valid=%b data=%h expected valid=1 data=400", vo[1], ro[1]);
                end
            end
            for (int d = 0; d < NI; d++) begin
                n_checks++;
                if (vo[d] !== exp_valid(1 << d) || (vo[d] === 1'b1 && ro[d] !== exp_data(1 << d))) begin
                    n_fail++;
                    $display("FAIL mul_basic_seq lat=%0d valid=%b data=%h expected valid=%b data=%h",
                             1 << d, vo[d], ro[d], exp_valid(1 << d), exp_data(1 << d));
                end
            end
        end
    endtask

    task automatic test_specials();
        // op, lane0 {sa,ca,sb,cb}; lane1 kept finite
        logic [4:0] tab [5] = '{5'b1_1_00_0, 5'b1_0_01_0, 5'b0_0_10_0, 5'b0_1_11_0, 5'b1_0_10_0};
        int         acl [5] = '{0, 1, 2, 3, 2};
        int         bcl [5] = '{1, 1, 1, 2, 1};
        idle();
        for (int t = 0; t < 5; t++) begin
            op_div = tab[t][4]; valid_in = 1'b1;
            set_lane(0, tab[t][3], acl[t], 1'b0, bcl[t]);
            set_lane(1, 1'b0, 0, 1'b0, 0);
            step();
            if (t == 0) begin
                n_checks++;
                if (vo[0] !== 1'b1 || ro[0] !== 12'h441) begin
                    n_fail++;
                    $display("FAIL div_by_zero lat=1 valid=%b data=%h expected valid=1 data=441", vo[0], ro[0]);
                end
            end
            if (t == 1) begin
                n_checks++;
                if (vo[0] !== 1'b1 || ro[0] !== 12'h104) begin
                    n_fail++;
                    $display("FAIL zero_div_zero lat=1 valid=%b data=%h expected valid=1 data=104", vo[0], ro[0]);
                end
            end
            for (int d = 0; d < NI; d++) begin
                n_checks++;
                if (vo[d] !== exp_valid(1 << d) || (vo[d] === 1'b1 && ro[d] !== exp_data(1 << d))) begin
                    n_fail++;
                    $display("FAIL specials lat=%0d valid=%b data=%h expected valid=%b data=%h",
                             1 << d, vo[d], ro[d], exp_valid(1 << d), exp_data(1 << d));
                end
            end
        end
        valid_in = 1'b0;
        for (int c = 0; c < 9; c++) step();
    endtask

    task automatic test_stall();
        logic pe [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        logic pv [12] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        int   n_out = 0;
        idle();
        for (int c = 0; c < 12; c++) begin
            en = pe[c]; valid_in = pv[c];
            op_div = c[0];
            set_lane(0, c[1], c % 3, c[0], (c + 1) % 4);
            set_lane(1, c[2], (c + 2) % 4, c[1], c % 2);
            step();
            if (pe[c] && vo[1] === 1'b1) n_out++;
            for (int d = 0; d < NI; d++) begin
                n_checks++;
                if (vo[d] !== exp_valid(1 << d) || (vo[d] === 1'b1 && ro[d] !== exp_data(1 << d))) begin
                    n_fail++;
                    $display("FAIL stall lat=%0d cyc=%0d valid=%b data=%h expected valid=%b data=%h",
                             1 << d, c, vo[d], ro[d], exp_valid(1 << d), exp_data(1 << d));
                end
            end
        end
        n_checks++;
        if (n_out !== 4) begin
            n_fail++;
            $display("FAIL stall_count lat=2 results=%0d expected 4", n_out);
        end
        idle();
        for (int c = 0; c < 9; c++) step();
    endtask

    task automatic test_flush();
        int n_out = 0;
        idle();
        op_div = 1'b1;
        for (int c = 0; c < 3; c++) begin
            valid_in = 1'b1;
            set_lane(0, 1'b1, c, 1'b0, 0);
            set_lane(1, 1'b0, 0, 1'b1, c);
            step();
        end
        valid_in = 1'b0; en = 1'b0; flush = 1'b1;
        step();
        idle();
        for (int c = 0; c < 4; c++) begin
            step();
            if (vo[2] === 1'b1) n_out++;
            for (int d = 0; d < NI; d++) begin
                n_checks++;
                if (vo[d] !== exp_valid(1 << d)) begin
                    n_fail++;
                    $display("FAIL flush lat=%0d valid=%b expected %b", 1 << d, vo[d], exp_valid(1 << d));
                end
            end
        end
        n_checks++;
        if (n_out !== 0) begin
            n_fail++;
            $display("FAIL flush_drain lat=4 results=%0d expected 0", n_out);
        end
        valid_in = 1'b1;
        set_lane(0, 1'b1, 0, 1'b0, 1);
        step();
        valid_in = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_checks++;
            if (vo[2] !== (c == 3)) begin
                n_fail++;
                $display("FAIL flush_refill lat=4 cyc=%0d valid=%b expected %b", c, vo[2], c == 3);
            end
        end
    endtask

    task automatic test_arst();
        idle();
        for (int c = 0; c < 5; c++) begin
            valid_in = 1'b1; op_div = c[0];
            set_lane(0, c[0], c % 4, 1'b1, (c + 1) % 3);
            set_lane(1, 1'b1, 2, c[1], 0);
            step();
        end
        valid_in = 1'b0; en = 1'b0; arst = 1'b1;
        step();
        for (int d = 0; d < NI; d++) begin
            n_checks++;
            if (vo[d] !== 1'b0 || ro[d] !== 12'h000) begin
                n_fail++;
                $display("FAIL arst_mid lat=%0d valid=%b data=%h expected valid=0 data=000", 1 << d, vo[d], ro[d]);
            end
        end
        arst = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            arst     = 1'b0;
            en       = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            valid_in = en && ($urandom_range(0, 3) != 0);
            op_div   = $urandom_range(0, 1);
            for (int l = 0; l < 2; l++) begin
                int a = $urandom_range(0, 5);
                int b = $urandom_range(0, 5);
                set_lane(l, 1'($urandom_range(0, 1)), (a > 3) ? 0 : a, 1'($urandom_range(0, 1)), (b > 3) ? 0 : b);
            end
            step();
            for (int d = 0; d < NI; d++) begin
                n_checks++;
                if (vo[d] !== exp_valid(1 << d) || (vo[d] === 1'b1 && ro[d] !== exp_data(1 << d))) begin
                    n_fail++;
                    $display("FAIL random lat=%0d cyc=%0d valid=%b data=%h expected valid=%b data=%h",
                             1 << d, c, vo[d], ro[d], exp_valid(1 << d), exp_data(1 << d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_specials();
        test_stall();
        test_flush();
        test_arst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sign_class_pipe.md
Name: sign_class_pipe

Overview:
- Parametrised successor to the 2-stage sign XOR pipeline used by the FP multiplier/divider.
- Per lane, computes result sign plus IEEE-754 special-case classification (NaN/Inf/zero, invalid, divide-by-zero) for MUL or DIV.
- Delay is programmable so the output aligns with the mantissa/exponent datapath.
- Adds valid tracking, stall (en) and flush, which the earlier block lacked.

Parameters:
- LANES, 1, number of independent operand pairs processed per cycle.
- LATENCY, 2, register stages from input to output; legal range 1..8 (elaboration error otherwise).

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- arst  input  1  reset; synchronous, active-high.
- en  input  1  advance enable; 0 freezes every stage (data and valid).
- flush  input  1  synchronous clear of all in-flight valid bits.
- valid_in  input  1  input operands valid this cycle.
- op_div  input  1  0 = multiply, 1 = divide; applies to all lanes.
- s_a, s_b  input  LANES  operand sign bits, bit i = lane i.
- a_zero, a_inf, a_nan  input  LANES  operand A class flags (mutually exclusive per lane; all 0 = finite nonzero).
- b_zero, b_inf, b_nan  input  LANES  operand B class flags, same rules.
- valid_out  output  1  result valid.
- s_r  output  LANES  result sign.
- r_nan, r_inf, r_zero  output  LANES  result class.
- r_inv  output  LANES  invalid-operation flag.
- r_dbz  output  LANES  divide-by-zero flag.

Behaviour:
- Combinational stage 0, per lane:
  - nan_in = a_nan|b_nan.
  - MUL: inv = (a_inf&b_zero)|(a_zero&b_inf).
  - DIV: inv = (a_inf&b_inf)|(a_zero&b_zero).
  - r_nan = nan_in|inv.
  - r_inv = inv & ~nan_in (a NaN operand never raises invalid).
  - MUL: r_inf = ~r_nan&(a_inf|b_inf); r_zero = ~r_nan&(a_zero|b_zero).
  - DIV: r_inf = ~r_nan&(a_inf|b_zero); r_zero = ~r_nan&(a_zero|b_inf).
  - r_dbz = op_div & b_zero & ~a_zero & ~a_inf & ~a_nan; always 0 for MUL.
  - s_r = r_nan ? 0 (canonical qNaN sign) : s_a^s_b.
- Pipeline: LATENCY register stages, each holding valid plus the 6*LANES result bits. With en held 1, inputs presented at edge N appear on the outputs after edge N+LATENCY-1, i.e. latency is exactly LATENCY cycles.
- Priority per edge: arst > flush > en.
- arst=1: every stage valid=0 and all data bits=0, so all outputs read 0 after the edge, regardless of en.
- flush=1 (arst=0): every valid bit cleared regardless of en; data registers hold.
  - valid_in in the same cycle is dropped.
  - Output data bits are don't-care while valid_out=0; the bench checks them only when valid_out=1.
- en=0 (no arst/flush): all stages hold; valid_in is ignored that cycle. The upstream only asserts valid_in when en=1.
- en=1: the whole pipeline shifts one stage. Bubbles (valid_in=0) propagate as valid=0, and their data is still registered.
- Class flags that violate mutual exclusivity: result undefined. An assertion in the RTL flags this in simulation only.
- Lanes are fully independent; only op_div, valid, en and flush are shared.

Decomposition:
- Shared package fp_md_pkg:
  - op_e enum (OP_MUL=0, OP_DIV=1).
  - fp_class_t struct {zero, inf, nan}.
  - sign_res_t struct {s, nan, inf, zero, inv, dbz}.
  - MAX_LATENCY=8.
- Sub-module sign_class_lane: combinational single-lane classification, instantiated LANES times via generate.
- The pipeline register array and its valid/flush control stay in the top module.

Test Plan:
- LANES=2, LATENCY=2, MUL, lane0 s_a=1,s_b=0 finite, lane1 s_a=1,s_b=1 finite, valid_in=1 one cycle -> after 2 edges valid_out=1, s_r=2'b01, all class flags 0, then valid_out=0.
- DIV lane0 a finite s=1, b_zero s=0 -> s_r=1, r_inf=1, r_dbz=1, r_inv=0. DIV lane0 a_zero, b_zero -> r_nan=1, r_inv=1, s_r=0. MUL a_inf × b_zero -> r_nan=1, r_inv=1, s_r=0.
- MUL a_nan(s=1) × b_inf -> r_nan=1, r_inv=0, r_inf=0, s_r=0. DIV a_inf / b_zero -> r_inf=1, r_dbz=0.
- Stream 4 consecutive valid inputs, drop en for 3 cycles after the 2nd -> outputs frozen during the stall, all 4 results emerge in order and none is duplicated or lost.
- Fill the LATENCY=4 pipeline with 3 valid items, assert flush 1 cycle with en=0 -> valid_out stays 0 for the next 4 cycles. A new input after the flush appears exactly 4 cycles later.
- Assert arst mid-stream with en=0 -> after the edge valid_out=0 and all outputs 0. Sweep LATENCY=1 and 8 for latency checks.
